y86_seq_ctrl: RTL and testbench

Parametrised run-control and status sequencer for the Y86-64 SEQ processor. Owns the architectural program counter and the processor status code, and sequences execution in free-run, single-step and breakpoint modes. Stops cleanly on halt, invalid instruction, address fault or cycle-budget exhaustion. Sits at the top of the SEQ datapath, taking the next PC from pc_update and fault flags from fetch and memory, and driving p_ctr and a commit enable back into the stages.

---
 rtl/y86_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_y86_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_ctrl.sv
// Run-control and status sequencer for the Y86-64 SEQ processor: owns p_ctr and
// stat, sequences free-run, single-step and breakpoint execution.
module y86_seq_ctrl #(
  parameter int unsigned      PC_W       = 64,
  parameter int unsigned      CNT_W      = 32,
  parameter logic [PC_W-1:0]  RESET_PC   = '0,
  parameter logic [CNT_W-1:0] MAX_CYCLES = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step_req,
  input  logic             load_pc,
  input  logic [PC_W-1:0]  load_addr,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  p_ctr_final,
  input  logic             in_error,
  input  logic             bad_mem,
  input  logic             bad_mem2,
  input  logic             flag_halt,
  output logic [PC_W-1:0]  p_ctr,
  output logic             exec_en,
  output logic [3:0]       stat,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0010;
  localparam logic [3:0] STAT_ADR = 4'b0001;
  localparam logic [3:0] STAT_INS = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STEP    = 2'd2,
    S_STOPPED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  p_ctr_q, p_ctr_d;
  logic [3:0]       stat_q, stat_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  logic [CNT_W-1:0] cyc_inc_c;
  logic [CNT_W-1:0] ins_inc_c;
  logic             fault_c;
  logic [3:0]       fault_stat_c;
  logic             budget_hit_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      p_ctr_q     <= RESET_PC;
      stat_q      <= STAT_AOK;
      timeout_q   <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      p_ctr_q     <= p_ctr_d;
      stat_q      <= stat_d;
      timeout_q   <= timeout_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Next-state, fault resolution and counter update
  always_comb begin
    state_d      = state_q;
    p_ctr_d      = p_ctr_q;
    stat_d       = stat_q;
    timeout_d    = timeout_q;
    cycle_cnt_d  = cycle_cnt_q;
    instr_cnt_d  = instr_cnt_q;
    fault_c      = 1'b1;
    fault_stat_c = STAT_AOK;

    cyc_inc_c = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    ins_inc_c = (instr_cnt_q == '1) ? instr_cnt_q : instr_cnt_q + CNT_W'(1);
    budget_hit_c = (MAX_CYCLES != '0) && (cyc_inc_c >= MAX_CYCLES);

    // Fault priority: INS > data ADR > HLT > fetch ADR
    if (in_error)       fault_stat_c = STAT_INS;
    else if (bad_mem2)  fault_stat_c = STAT_ADR;
    else if (flag_halt) fault_stat_c = STAT_HLT;
    else if (bad_mem)   fault_stat_c = STAT_ADR;
    else                fault_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_pc) p_ctr_d = load_addr;
        if (start)         state_d = S_RUN;
        else if (step_req) state_d = S_STEP;
      end
      S_RUN, S_STEP: begin
        cycle_cnt_d = cyc_inc_c;
        if (fault_c) begin
          stat_d  = fault_stat_c;
          state_d = S_STOPPED;
        end else begin
          p_ctr_d     = p_ctr_final;
          instr_cnt_d = ins_inc_c;
          if (budget_hit_c) begin
            state_d   = S_STOPPED;
            timeout_d = 1'b1;
          end else if (state_q == S_STEP) begin
            state_d = S_IDLE;
          end else if (bp_en && (p_ctr_final == bp_addr)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_STOPPED;
    endcase
  end

  assign p_ctr     = p_ctr_q;
  assign stat      = stat_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
  assign running   = (state_q == S_RUN) || (state_q == S_STEP);
  assign exec_en   = running;
  assign done      = (state_q == S_STOPPED);

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Self-checking bench for y86_seq_ctrl: directed scenarios plus randomized runs
// checked every cycle against a behavioural model.
module tb_y86_seq_ctrl;

  localparam int unsigned PC_W  = 64;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned MAXC  = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic             start, step_req, load_pc, bp_en;
  logic [PC_W-1:0]  load_addr, bp_addr, p_ctr_final;
  logic             in_error, bad_mem, bad_mem2, flag_halt;
  logic [PC_W-1:0]  p_ctr;
  logic             exec_en, running, done, timeout;
  logic [3:0]       stat;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 idle, 1 free-run, 2 single-step, 3 stopped
  int          m_mode;
  logic [63:0] m_pc;
  logic [3:0]  m_stat;
  logic        m_to;
  longint      m_cyc, m_ins;

  y86_seq_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RESET_PC('0), .MAX_CYCLES(CNT_W'(MAXC))
  ) dut (
    .clock(clock), .reset(reset), .start(start), .step_req(step_req),
    .load_pc(load_pc), .load_addr(load_addr), .bp_en(bp_en), .bp_addr(bp_addr),
    .p_ctr_final(p_ctr_final), .in_error(in_error), .bad_mem(bad_mem),
    .bad_mem2(bad_mem2), .flag_halt(flag_halt), .p_ctr(p_ctr), .exec_en(exec_en),
    .stat(stat), .running(running), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = '0; m_stat = 4'b1000; m_to = 1'b0; m_cyc = 0; m_ins = 0;
  endtask

  task automatic model_edge();
    logic [3:0] f;
    if (m_mode == 0) begin
      if (load_pc) m_pc = load_addr;
      if (start) m_mode = 1;
      else if (step_req) m_mode = 2;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      f = in_error ? 4'b0100 : bad_mem2 ? 4'b0001 : flag_halt ? 4'b0010 :
          bad_mem ? 4'b0001 : 4'b0000;
      if (f != 4'b0000) begin
        m_stat = f;
        m_mode = 3;
      end else begin
        m_pc = p_ctr_final;
        if (m_ins < 64'hFFFF_FFFF) m_ins++;
        if (MAXC != 0 && m_cyc >= longint'(MAXC)) begin
          m_mode = 3; m_to = 1'b1;
        end else if (m_mode == 2 || (bp_en && p_ctr_final == bp_addr)) begin
          m_mode = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic run_e;
    run_e = (m_mode == 1 || m_mode == 2);
    chk({tag, ".p_ctr"}, p_ctr, m_pc);
    chk({tag, ".stat"}, 64'(stat), 64'(m_stat));
    chk({tag, ".running"}, 64'(running), 64'(run_e));
    chk({tag, ".exec_en"}, 64'(exec_en), 64'(run_e));
    chk({tag, ".done"}, 64'(done), 64'(m_mode == 3));
    chk({tag, ".timeout"}, 64'(timeout), 64'(m_to));
    chk({tag, ".cycle_cnt"}, 64'(cycle_cnt), m_cyc);
    chk({tag, ".instr_cnt"}, 64'(instr_cnt), m_ins);
  endtask

  task automatic idle_inputs();
    start = 0; step_req = 0; load_pc = 0; load_addr = '0; bp_en = 0; bp_addr = '0;
    p_ctr_final = '0; in_error = 0; bad_mem = 0; bad_mem2 = 0; flag_halt = 0;
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later
  task automatic tick(input string tag);
    @(posedge clock);
    if (!reset) model_edge();
    #1;
    check_all(tag);
    @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1;
    idle_inputs();
    model_reset();
    #1;
    check_all(tag);
    @(negedge clock);
    reset = 0;
  endtask

  int en_cnt;

  initial begin
    reset = 1;
    idle_inputs();
    model_reset();
    #1;
    check_all("por");
    chk("por.stat_const", 64'(stat), 64'h8);
    chk("por.p_ctr_const", p_ctr, 64'h0);

    // Free-run to halt
    do_reset("rst1");
    start = 1; tick("fr.start"); start = 0;
    p_ctr_final = 10; tick("fr.c1");
    p_ctr_final = 20; tick("fr.c2");
    p_ctr_final = 30; tick("fr.c3");
    flag_halt = 1; p_ctr_final = 38; tick("fr.halt"); flag_halt = 0;
    chk("fr.p_ctr", p_ctr, 64'd30);
    chk("fr.stat", 64'(stat), 64'b0010);
    chk("fr.instr", 64'(instr_cnt), 64'd3);
    chk("fr.cycle", 64'(cycle_cnt), 64'd4);
    chk("fr.done", 64'(done), 64'd1);
    start = 1; step_req = 1; load_pc = 1; load_addr = 64'h99; tick("fr.sticky");
    idle_inputs();
    chk("fr.sticky_pc", p_ctr, 64'd30);

    // Fault priority: INS beats data ADR
    do_reset("rst2");
    start = 1; tick("pr.start"); start = 0;
    p_ctr_final = 8; tick("pr.c1");
    p_ctr_final = 16; in_error = 1; bad_mem2 = 1; tick("pr.c2");
    in_error = 0; bad_mem2 = 0;
    chk("pr.stat", 64'(stat), 64'b0100);
    chk("pr.p_ctr", p_ctr, 64'd8);
    chk("pr.instr", 64'(instr_cnt), 64'd1);
    chk("pr.exec_en", 64'(exec_en), 64'd0);
    start = 1; tick("pr.restart"); start = 0;
    chk("pr.still_done", 64'(done), 64'd1);

    // Breakpoint stop and resume
    do_reset("rst3");
    bp_en = 1; bp_addr = 64'h14;
    start = 1; tick("bp.start"); start = 0;
    p_ctr_final = 64'h0A; tick("bp.c1");
    p_ctr_final = 64'h14; tick("bp.c2");
    chk("bp.p_ctr", p_ctr, 64'h14);
    chk("bp.instr", 64'(instr_cnt), 64'd2);
    chk("bp.idle", 64'({running, done}), 64'd0);
    chk("bp.stat", 64'(stat), 64'h8);
    start = 1; tick("bp.resume"); start = 0;
    p_ctr_final = 64'h1E; tick("bp.c3");
    chk("bp.p_ctr2", p_ctr, 64'h1E);
    chk("bp.running2", 64'(running), 64'd1);

    // Single-step from a loaded PC
    do_reset("rst4");
    load_pc = 1; load_addr = 64'h40; tick("st.load"); load_pc = 0;
    chk("st.loaded", p_ctr, 64'h40);
    en_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step_req = 1; tick("st.req"); step_req = 0;
      if (exec_en) en_cnt++;
      p_ctr_final = 64'h40 + 64'(8 * (i + 1)); tick("st.exec");
      if (exec_en) en_cnt++;
      chk("st.idle_between", 64'(running), 64'd0);
      tick("st.gap");
      if (exec_en) en_cnt++;
    end
    chk("st.exec_cycles", 64'(en_cnt), 64'd3);
    chk("st.instr", 64'(instr_cnt), 64'd3);
    chk("st.p_ctr", p_ctr, 64'h58);

    // Cycle budget
    do_reset("rst5");
    start = 1; tick("bu.start"); start = 0;
    for (int i = 0; i < 5; i++) begin
      p_ctr_final = 64'(100 + 4 * i); tick("bu.cyc");
    end
    chk("bu.done", 64'(done), 64'd1);
    chk("bu.timeout", 64'(timeout), 64'd1);
    chk("bu.stat", 64'(stat), 64'h8);
    chk("bu.instr", 64'(instr_cnt), 64'd5);
    chk("bu.p_ctr", p_ctr, 64'd116);

    // Asynchronous reset between edges
    do_reset("rst6");
    start = 1; tick("ar.start"); start = 0;
    p_ctr_final = 64'h20; tick("ar.c1");
    #2 reset = 1;
    #1;
    chk("ar.p_ctr", p_ctr, 64'h0);
    chk("ar.cycle", 64'(cycle_cnt), 64'd0);
    chk("ar.instr", 64'(instr_cnt), 64'd0);
    chk("ar.exec_en", 64'(exec_en), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 0;
    start = 1; tick("ar.restart"); start = 0;
    p_ctr_final = 64'h30; tick("ar.c2");
    chk("ar.p_ctr2", p_ctr, 64'h30);

    // Randomized sequences against the model
    for (int r = 0; r < 40; r++) begin
      do_reset("rnd.rst");
      for (int c = 0; c < 20; c++) begin
        start       = ($urandom_range(0, 3) == 0);
        step_req    = ($urandom_range(0, 2) == 0);
        load_pc     = ($urandom_range(0, 3) == 0);
        load_addr   = 64'($urandom_range(0, 7)) << 3;
        bp_en       = $urandom_range(0, 1) == 1;
        bp_addr     = 64'($urandom_range(0, 7)) << 3;
        p_ctr_final = 64'($urandom_range(0, 7)) << 3;
        in_error    = ($urandom_range(0, 19) == 0);
        bad_mem     = ($urandom_range(0, 19) == 0);
        bad_mem2    = ($urandom_range(0, 19) == 0);
        flag_halt   = ($urandom_range(0, 19) == 0);
        tick("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
